uart_tx_serializer: RTL and testbench

Transmit-side serializer of the UART. Accepts one parallel character per valid/ready handshake and shifts it onto the serial line as start bit, LSB-first data, optional parity and one or two stop bits. Every bit boundary is aligned to `baud_tick`, the one-cycle-per-bit-period strobe from the baud generator in the same clock domain. Sits between the host-side transmit interface and the `tx_serial` pad.

---
 rtl/uart_tx_serializer.sv | 145 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer; start, LSB-first data, optional parity, 1/2 stops.
// Every bit boundary aligned to baud_tick; all outputs registered. Rev 1.0
`default_nettype none

module uart_tx_serializer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 system_clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 two_stop_q, two_stop_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 accept;

  // ready_q mirrors "in IDLE and out of reset", so it doubles as the handshake qualifier
  assign accept = tx_valid && ready_q;

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_SYNC;
          data_d     = tx_data;
          par_en_d   = parity_en;
          par_odd_d  = parity_odd;
          two_stop_d = two_stop;
          idx_d      = '0;
          stop_d     = 1'b0;
        end
      end
      S_SYNC: if (baud_tick) state_d = S_START;
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (idx_q == LAST_IDX) state_d = par_en_q ? S_PARITY : S_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_PARITY: if (baud_tick) state_d = S_STOP;
      S_STOP: begin
        if (baud_tick) begin
          if (two_stop_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered line changes one cycle after the tick
  always_comb begin
    serial_d = 1'b1;
    busy_d   = (state_d != S_IDLE);
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = data_q[idx_d];
      S_PARITY: serial_d = (^data_q) ^ par_odd_q;
      default:  serial_d = 1'b1;
    endcase
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign tx_ready  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer, driven tick by tick.
`default_nettype none

module tb_uart_tx_serializer;

  localparam int DB = 8;

  typedef struct packed {
    logic line;
    logic done;
  } exp_t;

  logic          system_clk = 1'b0;
  logic          reset      = 1'b1;
  logic          baud_tick  = 1'b0;
  logic [DB-1:0] tx_data    = '0;
  logic          tx_valid   = 1'b0;
  logic          parity_en  = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop   = 1'b0;
  logic          tx_ready;
  logic          tx_serial;
  logic          tx_busy;
  logic          tx_done;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  always #5 system_clk = ~system_clk;

  uart_tx_serializer #(.DATA_BITS(DB)) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  // Expected line level after each tick of a frame; the last entry is the idle/done cycle.
  task automatic push_frame(input logic [DB-1:0] d, input logic pe, input logic po, input logic ts);
    sb.push_back('{line: 1'b0, done: 1'b0});
    for (int i = 0; i < DB; i++) sb.push_back('{line: d[i], done: 1'b0});
    if (pe) sb.push_back('{line: ((^d) ^ po), done: 1'b0});
    sb.push_back('{line: 1'b1, done: 1'b0});
    if (ts) sb.push_back('{line: 1'b1, done: 1'b0});
    sb.push_back('{line: 1'b1, done: 1'b1});
  endtask

  // Accept one character from IDLE; config inputs are flipped right after to prove they were latched.
  task automatic send(input logic [DB-1:0] d, input logic pe, input logic po, input logic ts,
                      input logic tick_now);
    tx_data = d; parity_en = pe; parity_odd = po; two_stop = ts;
    tx_valid = 1'b1; baud_tick = tick_now;
    @(negedge system_clk);
    tx_valid = 1'b0; baud_tick = 1'b0;
    tx_data = ~d; parity_en = ~pe; parity_odd = ~po; two_stop = ~ts;
    n_checks++;
    if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1010)
      $display("FAIL accept: ser/done/busy/rdy=%b expected 1010", {tx_serial, tx_done, tx_busy, tx_ready});
    else n_pass++;
    push_frame(d, pe, po, ts);
  endtask

  task automatic sync_hold(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge system_clk);
      n_checks++;
      if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1010)
        $display("FAIL sync_hold: ser/done/busy/rdy=%b expected 1010", {tx_serial, tx_done, tx_busy, tx_ready});
      else n_pass++;
    end
  endtask

  // Pops every queued entry; gap <= 0 picks a random tick spacing per bit.
  task automatic run_frame(input int gap);
    int   n;
    int   g;
    exp_t e;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      g = (gap > 0) ? gap : int'($urandom_range(2, 9));
      baud_tick = 1'b1;
      @(negedge system_clk);
      baud_tick = 1'b0;
      n_checks++;
      if ({tx_serial, tx_done, tx_busy, tx_ready} !== {e.line, e.done, ~e.done, e.done})
        $display("FAIL frame_tick%0d: ser/done/busy/rdy=%b expected %b", k + 1,
                 {tx_serial, tx_done, tx_busy, tx_ready}, {e.line, e.done, ~e.done, e.done});
      else n_pass++;
      if (!e.done) begin
        for (int c = 1; c < g; c++) begin
          @(negedge system_clk);
          n_checks++;
          if ({tx_serial, tx_done, tx_busy, tx_ready} !== {e.line, 3'b010})
            $display("FAIL bit_hold%0d: ser/done/busy/rdy=%b expected %b", k + 1,
                     {tx_serial, tx_done, tx_busy, tx_ready}, {e.line, 3'b010});
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      baud_tick = ~baud_tick;
      @(negedge system_clk);
      n_checks++;
      if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1000)
        $display("FAIL reset_hold: ser/done/busy/rdy=%b expected 1000", {tx_serial, tx_done, tx_busy, tx_ready});
      else n_pass++;
    end
    reset = 1'b0; baud_tick = 1'b0;
    @(negedge system_clk);
    n_checks++;
    if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1001)
      $display("FAIL reset_release: ser/done/busy/rdy=%b expected 1001", {tx_serial, tx_done, tx_busy, tx_ready});
    else n_pass++;
  endtask

  task automatic test_8n1();
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    sync_hold(15);
    run_frame(16);
  endtask

  task automatic test_parity();
    repeat (2) @(negedge system_clk);
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    sync_hold(4);
    run_frame(5);
    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    sync_hold(4);
    run_frame(5);
    send(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    sync_hold(2);
    run_frame(0);
    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    sync_hold(3);
    run_frame(4);
  endtask

  task automatic test_back_to_back();
    repeat (2) @(negedge system_clk);
    tx_data = 8'h55; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; tx_valid = 1'b1;
    @(negedge system_clk);
    n_checks++;
    if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1010)
      $display("FAIL b2b_accept1: ser/done/busy/rdy=%b expected 1010", {tx_serial, tx_done, tx_busy, tx_ready});
    else n_pass++;
    push_frame(8'h55, 1'b0, 1'b0, 1'b0);
    sync_hold(5);
    fork
      run_frame(6);
      begin
        repeat (20) @(negedge system_clk);
        tx_data = 8'hFF; parity_en = 1'b1; two_stop = 1'b1;
        repeat (20) @(negedge system_clk);
        tx_data = 8'h3C; parity_en = 1'b0; two_stop = 1'b0;
      end
    join
    @(negedge system_clk);
    tx_valid = 1'b0;
    n_checks++;
    if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1010)
      $display("FAIL b2b_accept2: ser/done/busy/rdy=%b expected 1010", {tx_serial, tx_done, tx_busy, tx_ready});
    else n_pass++;
    push_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    sync_hold(5);
    run_frame(6);
  endtask

  task automatic test_reset_mid_frame();
    repeat (2) @(negedge system_clk);
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.delete();
    repeat (5) begin
      repeat (3) @(negedge system_clk);
      baud_tick = 1'b1;
      @(negedge system_clk);
      baud_tick = 1'b0;
    end
    n_checks++;
    if ({tx_serial, tx_busy} !== 2'b01)
      $display("FAIL midframe_bit3: ser/busy=%b expected 01", {tx_serial, tx_busy});
    else n_pass++;
    reset = 1'b1;
    @(negedge system_clk);
    reset = 1'b0;
    n_checks++;
    if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1000)
      $display("FAIL midframe_reset: ser/done/busy/rdy=%b expected 1000", {tx_serial, tx_done, tx_busy, tx_ready});
    else n_pass++;
    @(negedge system_clk);
    n_checks++;
    if ({tx_serial, tx_done, tx_busy, tx_ready} !== 4'b1001)
      $display("FAIL midframe_release: ser/done/busy/rdy=%b expected 1001", {tx_serial, tx_done, tx_busy, tx_ready});
    else n_pass++;
    send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    sync_hold(5);
    run_frame(6);
  endtask

  task automatic test_coincident_tick();
    repeat (2) @(negedge system_clk);
    send(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
    sync_hold(3);
    run_frame(4);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_coincident_tick();
    repeat (3) @(negedge system_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
